// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: TXDATA stores feed a circular TX FIFO that a
// serializer drains as contiguous frames; STATUS exposes count/overflow/empty/full/busy.
module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_1000,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        dmem_write,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_data_in,
    output logic        mmio_sel,
    output logic [31:0] mmio_rdata,
    output logic        uart_tx,
    output logic        tx_irq
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int BCNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

    state_e            state_q;
    logic [BCNT_W-1:0] bcnt_q;
    logic [2:0]        bit_idx_q;
    logic [7:0]        shift_q;
    logic              uart_tx_q;
    logic              tx_irq_q;

    logic [7:0]        fifo_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  count_d;
    logic              overflow_q;

    logic txdata_wr, status_wr, fifo_empty, fifo_full, push, pop, bcnt_last, fsm_idle_d;
    logic unused_bits;

    assign unused_bits = ^{dmem_addr[1:0], dmem_data_in[31:8]};

    assign mmio_sel   = (dmem_addr[31:3] == BASE_ADDR[31:3]);
    assign txdata_wr  = dmem_write && mmio_sel && !dmem_addr[2];
    assign status_wr  = dmem_write && mmio_sel &&  dmem_addr[2];
    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CNT_FULL);
    assign bcnt_last  = (bcnt_q == BCNT_LAST);

    // Fullness uses the pre-edge count, so a same-cycle pop never rescues a push.
    assign push = txdata_wr && !fifo_full;
    assign pop  = !fifo_empty && ((state_q == IDLE) || (state_q == STOP && bcnt_last));
    assign fsm_idle_d = fifo_empty && ((state_q == IDLE) || (state_q == STOP && bcnt_last));

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_comb begin
        mmio_rdata = '0;
        if (mmio_sel && dmem_addr[2]) begin
            mmio_rdata = {16'b0, 8'(count_q), 4'b0, overflow_q, fifo_empty, fifo_full,
                          state_q != IDLE};
        end
    end

    // NOTE: FIFO storage has no reset; only pointers/count define validity, so it maps to plain RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= dmem_data_in[7:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_d;
            if (txdata_wr && fifo_full) begin
                overflow_q <= 1'b1;
            end else if (status_wr && dmem_data_in[3]) begin
                overflow_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            bcnt_q    <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            uart_tx_q <= 1'b1;
            tx_irq_q  <= 1'b1;
        end else begin
            tx_irq_q <= fsm_idle_d && (count_d == '0);
            case (state_q)
                IDLE: begin
                    uart_tx_q <= 1'b1;
                    if (pop) begin
                        shift_q   <= fifo_q[rd_ptr_q];
                        uart_tx_q <= 1'b0;
                        bcnt_q    <= '0;
                        state_q   <= START;
                    end
                end
                START: begin
                    if (bcnt_last) begin
                        bcnt_q    <= '0;
                        bit_idx_q <= '0;
                        uart_tx_q <= shift_q[0];
                        state_q   <= DATA;
                    end else begin
                        bcnt_q <= bcnt_q + BCNT_W'(1);
                    end
                end
                DATA: begin
                    if (bcnt_last) begin
                        bcnt_q <= '0;
                        if (bit_idx_q == 3'd7) begin
                            uart_tx_q <= 1'b1;
                            state_q   <= STOP;
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                            shift_q   <= {1'b0, shift_q[7:1]};
                            uart_tx_q <= shift_q[1];
                        end
                    end else begin
                        bcnt_q <= bcnt_q + BCNT_W'(1);
                    end
                end
                STOP: begin
                    if (bcnt_last) begin
                        bcnt_q <= '0;
                        // Chain straight into the next start bit so frames stay contiguous.
                        if (pop) begin
                            shift_q   <= fifo_q[rd_ptr_q];
                            uart_tx_q <= 1'b0;
                            state_q   <= START;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else begin
                        bcnt_q <= bcnt_q + BCNT_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign uart_tx = uart_tx_q;
    assign tx_irq  = tx_irq_q;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Scoreboard bench for mmio_uart_tx: stores push expected bytes, a serial-line monitor
// decodes each frame and compares it against the queue head.
module tb_mmio_uart_tx;

    localparam int CPB = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        dmem_write;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_data_in;
    logic        mmio_sel;
    logic [31:0] mmio_rdata;
    logic        uart_tx;
    logic        tx_irq;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int frame_count = 0;
    int aborted  = 0;
    int starts_q[$];
    logic [7:0] exp_q[$];

    logic [7:0] mon_exp, mon_rx;
    logic [9:0] mon_frame;
    bit         mon_ok, mon_abort;

    mmio_uart_tx #(.BASE_ADDR(32'h0000_1000), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .dmem_write(dmem_write), .dmem_addr(dmem_addr),
        .dmem_data_in(dmem_data_in), .mmio_sel(mmio_sel), .mmio_rdata(mmio_rdata),
        .uart_tx(uart_tx), .tx_irq(tx_irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drives one store for the upcoming edge; leaves the strobe high for chaining.
    task automatic store(input logic [31:0] a, input logic [31:0] d, output int edge_no);
        dmem_addr    = a;
        dmem_data_in = d;
        dmem_write   = 1'b1;
        edge_no      = cyc + 1;
        @(negedge clk);
    endtask

    task automatic bus_idle();
        dmem_write = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string name);
        dmem_addr = a;
        #1;
        check(name, mmio_rdata, exp);
    endtask

    task automatic wait_frames(input int target, input int budget, input string name);
        int n;
        n = 0;
        while (frame_count < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, frame_count, target);
    endtask

    // Serial-line monitor: every low level on an idle line starts a frame.
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (!reset && uart_tx === 1'b0) begin
                starts_q.push_back(cyc);
                check("unexpected_frame", 32'(exp_q.size() != 0), 32'd1);
                mon_exp   = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
                mon_frame = {1'b1, mon_exp, 1'b0};
                mon_ok    = 1'b1;
                mon_abort = 1'b0;
                mon_rx    = 8'h00;
                for (int c = 0; c < 10 * CPB; c++) begin
                    if (c > 0) @(negedge clk);
                    if (reset) begin
                        mon_abort = 1'b1;
                        break;
                    end
                    if (uart_tx !== mon_frame[c / CPB]) mon_ok = 1'b0;
                    if (c / CPB >= 1 && c / CPB <= 8 && c % CPB == CPB / 2)
                        mon_rx[c / CPB - 1] = uart_tx;
                end
                if (mon_abort) begin
                    aborted++;
                end else begin
                    frame_count++;
                    check("frame_byte", 32'(mon_rx), 32'(mon_exp));
                    check("frame_shape", 32'(mon_ok), 32'd1);
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int s, e, b, fc, lows;
        reset        = 1'b1;
        dmem_write   = 1'b0;
        dmem_addr    = 32'h0;
        dmem_data_in = 32'h0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Reset / idle state
        check("reset_uart_tx", 32'(uart_tx), 32'd1);
        check("reset_tx_irq", 32'(tx_irq), 32'd1);
        rd(32'h1004, 32'h0000_0004, "reset_status");
        check("status_sel", 32'(mmio_sel), 32'd1);
        rd(32'h1000, 32'h0000_0000, "txdata_reads_zero");
        check("txdata_sel", 32'(mmio_sel), 32'd1);

        // Single frame 0xA5
        b = starts_q.size();
        exp_q.push_back(8'hA5);
        store(32'h1000, 32'h0000_00A5, s);
        bus_idle();
        check("irq_low_after_store", 32'(tx_irq), 32'd0);
        wait_frames(1, 100, "frame_a5_done");
        check("tx_fall_latency", 32'(starts_q[b]), 32'(s + 1));
        repeat (2) @(negedge clk);
        check("irq_high_after_frame", 32'(tx_irq), 32'd1);

        // Overflow burst 0x11..0x16, 0x16 dropped
        b = starts_q.size();
        for (int i = 0; i < 6; i++) begin
            if (i < 5) exp_q.push_back(8'(8'h11 + i));
            store(32'h1000, 32'(8'h11 + i), e);
            if (i == 0) s = e;
        end
        bus_idle();
        rd(32'h1004, 32'h0000_040B, "status_full_overflow");
        wait_frames(6, 400, "burst_frames_done");
        check("burst_first_start", 32'(starts_q[b]), 32'(s + 1));
        check("burst_contiguous", 32'(starts_q[b + 4] - starts_q[b]), 32'(4 * 10 * CPB));
        repeat (3) @(negedge clk);
        rd(32'h1004, 32'h0000_000C, "status_overflow_sticky");
        store(32'h1004, 32'h0000_0008, e);
        bus_idle();
        rd(32'h1004, 32'h0000_0004, "status_overflow_cleared");

        // Push coinciding with the STOP-end pop
        b = starts_q.size();
        exp_q.push_back(8'h21);
        exp_q.push_back(8'h22);
        exp_q.push_back(8'h23);
        store(32'h1000, 32'h0000_0021, s);
        store(32'h1000, 32'h0000_0022, e);
        bus_idle();
        while (cyc < s + 40) @(negedge clk);
        store(32'h1000, 32'h0000_0023, e);
        bus_idle();
        rd(32'h1004, 32'h0000_0101, "status_push_pop_same_cycle");
        wait_frames(9, 300, "pushpop_frames_done");
        check("pushpop_contiguous", 32'(starts_q[b + 2] - starts_q[b]), 32'(2 * 10 * CPB));

        // Reset mid-DATA of 0x3C with two bytes queued
        repeat (3) @(negedge clk);
        exp_q.push_back(8'h3C);
        store(32'h1000, 32'h0000_003C, s);
        store(32'h1000, 32'h0000_0041, e);
        store(32'h1000, 32'h0000_0042, e);
        bus_idle();
        repeat (7) @(negedge clk);
        check("pre_reset_data_bit1_low", 32'(uart_tx), 32'd0);
        #2 reset = 1'b1;
        #1;
        check("async_reset_uart_tx", 32'(uart_tx), 32'd1);
        check("async_reset_tx_irq", 32'(tx_irq), 32'd1);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        rd(32'h1004, 32'h0000_0004, "status_after_reset");
        check("frame_aborted", 32'(aborted), 32'd1);
        fc   = frame_count;
        lows = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (uart_tx !== 1'b1) lows++;
        end
        check("no_frames_after_reset", 32'(lows), 32'd0);
        check("frame_count_after_reset", 32'(frame_count), 32'(fc));

        // Out-of-window addresses
        dmem_addr    = 32'h0000_1008;
        dmem_data_in = 32'h0000_0055;
        dmem_write   = 1'b1;
        #1;
        check("miss_1008_sel", 32'(mmio_sel), 32'd0);
        check("miss_1008_rdata", mmio_rdata, 32'h0);
        @(negedge clk);
        dmem_addr = 32'h0000_0FFC;
        #1;
        check("miss_0ffc_sel", 32'(mmio_sel), 32'd0);
        check("miss_0ffc_rdata", mmio_rdata, 32'h0);
        @(negedge clk);
        bus_idle();
        rd(32'h1004, 32'h0000_0004, "status_after_miss");
        lows = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (uart_tx !== 1'b1) lows++;
        end
        check("miss_line_idle", 32'(lows), 32'd0);
        check("miss_tx_irq", 32'(tx_irq), 32'd1);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
